// File: rtl/mem_copy_engine_pkg.sv
// ShellTypes: shared memory-interface types and copy-engine command definitions
package ShellTypes;
  localparam int LINE_BYTES = 64;
  localparam int CMD_LINES_W = 32;
  typedef struct packed {
    logic         valid;
    logic         isWrite;
    logic [63:0]  addr;
    logic [511:0] data;
  } MemReq;
  typedef struct packed {
    logic         valid;
    logic [511:0] data;
  } MemResp;
  typedef struct packed {
    logic [63:0]            src;
    logic [63:0]            dst;
    logic [CMD_LINES_W-1:0] lines;
  } CopyCmd;
endpackage

// File: rtl/mem_copy_engine_if.sv
// mem_copy_engine_if: request/response bus between the copy engine and the memory interface
interface mem_copy_engine_if;
  import ShellTypes::*;
  MemReq  mem_req_out;
  logic   mem_req_ready_in;
  MemResp mem_resp_in;
  logic   mem_resp_ready_out;
  modport master(output mem_req_out, output mem_resp_ready_out, input mem_req_ready_in, input mem_resp_in);
  modport slave(input mem_req_out, input mem_resp_ready_out, output mem_req_ready_in, output mem_resp_in);
endinterface

// File: rtl/mem_copy_engine.sv
// mem_copy_engine: line-granular copy; reads src lines and writes each in-order response to dst
module mem_copy_engine
  import ShellTypes::*;
#(
  parameter int MAX_OUTSTANDING = 64,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [63:0]      cmd_src,
  input  logic [63:0]      cmd_dst,
  input  logic [CNT_W-1:0] cmd_lines,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] lines_done,
  mem_copy_engine_if.master mem
);
  localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN = 1'b1;
  logic [0:0] state;
  logic [63:0] srcBase, dstBase;
  logic [CNT_W-1:0] lines, rdIssued, wrIssued;
  logic [OUT_W-1:0] outstanding;
  logic run, doneZero, wrWant, rdWant, wrAcc, rdAcc, lastWr;
  assign run = state == RUN;
  // a waiting response always wins the single request slot
  assign wrWant = run && mem.mem_resp_in.valid;
  assign rdWant = run && !mem.mem_resp_in.valid && rdIssued < lines && outstanding < OUT_W'(MAX_OUTSTANDING);
  assign wrAcc = wrWant && mem.mem_req_ready_in;
  assign rdAcc = rdWant && mem.mem_req_ready_in;
  assign lastWr = wrAcc && wrIssued + CNT_W'(1) == lines;
  assign cmd_ready = !rst && state == IDLE;
  assign busy = run;
  assign done = doneZero || lastWr;
  assign mem.mem_resp_ready_out = run && mem.mem_req_ready_in;
  always_comb begin
    mem.mem_req_out.valid = wrWant || rdWant;
    mem.mem_req_out.isWrite = wrWant;
    mem.mem_req_out.addr = wrWant ? dstBase + 64'(wrIssued) * 64'(LINE_BYTES)
                                  : srcBase + 64'(rdIssued) * 64'(LINE_BYTES);
    mem.mem_req_out.data = wrWant ? mem.mem_resp_in.data : '0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      srcBase <= '0;
      dstBase <= '0;
      lines <= '0;
      rdIssued <= '0;
      wrIssued <= '0;
      outstanding <= '0;
      lines_done <= '0;
      doneZero <= 1'b0;
    end else begin
      doneZero <= 1'b0;
      if (state == IDLE && cmd_valid) begin
        srcBase <= cmd_src & ~64'h3F;
        dstBase <= cmd_dst & ~64'h3F;
        lines <= cmd_lines;
        rdIssued <= '0;
        wrIssued <= '0;
        outstanding <= '0;
        lines_done <= '0;
        doneZero <= cmd_lines == '0;
        state <= cmd_lines == '0 ? IDLE : RUN;
      end
      if (rdAcc) begin
        rdIssued <= rdIssued + CNT_W'(1);
        outstanding <= outstanding + OUT_W'(1);
      end
      if (wrAcc) begin
        wrIssued <= wrIssued + CNT_W'(1);
        outstanding <= outstanding - OUT_W'(1);
        lines_done <= wrIssued + CNT_W'(1);
      end
      if (lastWr) state <= IDLE;
    end
  end
endmodule

// File: tb/tb_mem_copy_engine.sv
// tb_mem_copy_engine: scoreboard bench with an in-order memory model behind the copy engine
module tb_mem_copy_engine;
  import ShellTypes::*;
  typedef struct { logic [63:0] a; logic [511:0] d; } wr_t;
  typedef struct { logic [511:0] d; int t; } rsp_t;
  logic clk = 1'b0, rst = 1'b1, cmd_valid = 1'b0;
  logic [63:0] cmd_src = '0, cmd_dst = '0;
  logic [31:0] cmd_lines = '0;
  logic cmd_ready, busy, done;
  logic [31:0] lines_done;
  logic [63:0] expRd[$];
  wr_t expWr[$];
  rsp_t respQ[$];
  int cyc = 0, nChecks = 0, nFail = 0, rdCnt = 0, wrCnt = 0, doneCnt = 0, reqCnt = 0, allow = 0;
  int lat = 5;
  bit hold = 0, randReady = 0;
  mem_copy_engine_if bus();
  mem_copy_engine #(.MAX_OUTSTANDING(4), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_src(cmd_src), .cmd_dst(cmd_dst), .cmd_lines(cmd_lines),
    .busy(busy), .done(done), .lines_done(lines_done), .mem(bus)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic logic [511:0] pat(input logic [63:0] a);
    return {8{a ^ 64'hC0DE_0000_0000_0000}};
  endfunction
  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic tick();
    @(negedge clk);
    #2;
  endtask
  // memory model + monitor: drives inputs at negedge, observes handshakes 1ns later
  initial begin
    wr_t e;
    logic [63:0] ea;
    bus.mem_req_ready_in = 1'b0;
    bus.mem_resp_in = '0;
    forever begin
      @(negedge clk);
      bus.mem_req_ready_in = randReady ? 1'($urandom_range(0, 1)) : 1'b1;
      if (respQ.size() > 0 && respQ[0].t <= cyc && (!hold || allow > 0)) begin
        bus.mem_resp_in.valid = 1'b1;
        bus.mem_resp_in.data = respQ[0].d;
      end else bus.mem_resp_in = '0;
      #1;
      if (rst) respQ.delete();
      else begin
        if (done) doneCnt++;
        if (bus.mem_resp_in.valid && bus.mem_resp_ready_out) begin
          chk("resp_pop_with_write", {bus.mem_req_out.valid, bus.mem_req_out.isWrite, bus.mem_req_ready_in}, 3'b111);
          void'(respQ.pop_front());
          if (allow > 0) allow--;
        end
        if (bus.mem_req_out.valid && bus.mem_req_ready_in) begin
          reqCnt++;
          if (bus.mem_req_out.isWrite) begin
            wrCnt++;
            if (expWr.size() == 0) begin
              nChecks++;
              nFail++;
              $display("FAIL unexpected_write: got addr %0h expected no write", bus.mem_req_out.addr);
            end else begin
              e = expWr.pop_front();
              chk("wr_addr", bus.mem_req_out.addr, e.a);
              chk("wr_data", bus.mem_req_out.data, e.d);
            end
          end else begin
            rdCnt++;
            if (expRd.size() == 0) begin
              nChecks++;
              nFail++;
              $display("FAIL unexpected_read: got addr %0h expected no read", bus.mem_req_out.addr);
            end else begin
              ea = expRd.pop_front();
              chk("rd_addr", bus.mem_req_out.addr, ea);
              chk("rd_data_zero", bus.mem_req_out.data, '0);
            end
            respQ.push_back('{pat(bus.mem_req_out.addr), cyc + lat});
          end
        end
      end
    end
  end
  task automatic issue(input logic [63:0] s, input logic [63:0] d, input logic [63:0] es,
                       input logic [63:0] ed, input int n);
    tick();
    chk("cmd_ready_idle", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_src = s;
    cmd_dst = d;
    cmd_lines = 32'(n);
    for (int i = 0; i < n; i++) begin
      expRd.push_back(es + 64'(i) * 64);
      expWr.push_back('{ed + 64'(i) * 64, pat(es + 64'(i) * 64)});
    end
    tick();
    cmd_valid = 1'b0;
  endtask
  task automatic wait_done(input string name, input int n);
    int d0 = doneCnt;
    for (int i = 0; i < 2000 && doneCnt == d0; i++) tick();
    repeat (3) tick();
    chk({name, "_done_once"}, doneCnt - d0, 1);
    chk({name, "_lines_done"}, lines_done, n);
    chk({name, "_idle_busy"}, busy, 0);
    chk({name, "_idle_ready"}, cmd_ready, 1);
    chk({name, "_rd_drained"}, expRd.size(), 0);
    chk({name, "_wr_drained"}, expWr.size(), 0);
  endtask
  initial begin
    int r0, w0, q0, d0;
    repeat (3) begin
      tick();
      chk("rst_cmd_ready", cmd_ready, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_lines_done", lines_done, 0);
      chk("rst_req_valid", bus.mem_req_out.valid, 0);
      chk("rst_resp_ready", bus.mem_resp_ready_out, 0);
    end
    rst = 1'b0;
    #1 chk("cmd_ready_after_rst", cmd_ready, 1);
    r0 = rdCnt;
    issue(64'h1000, 64'h8000, 64'h1000, 64'h8000, 4);
    chk("basic_busy", busy, 1);
    chk("basic_first_read_next_cycle", rdCnt - r0, 1);
    wait_done("basic", 4);
    q0 = reqCnt;
    d0 = doneCnt;
    issue(64'h1000, 64'h8000, 64'h1000, 64'h8000, 0);
    chk("zero_done_pulse", done, 1);
    chk("zero_not_busy", busy, 0);
    tick();
    chk("zero_done_low", done, 0);
    chk("zero_cmd_ready", cmd_ready, 1);
    repeat (5) tick();
    chk("zero_done_count", doneCnt - d0, 1);
    chk("zero_no_req", reqCnt - q0, 0);
    chk("zero_lines_done", lines_done, 0);
    hold = 1;
    allow = 0;
    r0 = rdCnt;
    w0 = wrCnt;
    issue(64'h4000, 64'hC000, 64'h4000, 64'hC000, 16);
    repeat (20) tick();
    chk("cap_reads_stall", rdCnt - r0, 4);
    chk("cap_no_writes", wrCnt - w0, 0);
    allow = 1;
    repeat (10) tick();
    chk("cap_release_write", wrCnt - w0, 1);
    chk("cap_release_read", rdCnt - r0, 5);
    hold = 0;
    wait_done("cap", 16);
    randReady = 1;
    issue(64'h20000, 64'h30000, 64'h20000, 64'h30000, 8);
    wait_done("backpressure", 8);
    randReady = 0;
    issue(64'h1007, 64'h203F, 64'h1000, 64'h2000, 2);
    wait_done("unaligned", 2);
    w0 = wrCnt;
    issue(64'h5000, 64'h9000, 64'h5000, 64'h9000, 8);
    for (int i = 0; i < 500 && wrCnt - w0 < 3; i++) tick();
    chk("rstmid_three_writes", wrCnt - w0, 3);
    rst = 1'b1;
    tick();
    chk("rstmid_req_valid", bus.mem_req_out.valid, 0);
    chk("rstmid_busy", busy, 0);
    chk("rstmid_lines_done", lines_done, 0);
    rst = 1'b0;
    expRd.delete();
    expWr.delete();
    #1 chk("rstmid_cmd_ready", cmd_ready, 1);
    issue(64'h7000, 64'hA000, 64'h7000, 64'hA000, 3);
    wait_done("after_rst", 3);
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL watchdog: got no completion expected finish before 500000ns");
    $fatal(1, "watchdog expired");
  end
endmodule
